control_word_sequencer: RTL

Sequencer for the 8259A command path. It sits behind the read/write decode on the internal bus and tracks where the device is in the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence. It commits each CPU write into the correct ICW/OCW register and drives the configuration, mask and one-cycle command pulses consumed by the priority resolver, ISR/IRR and cascade logic.

---
 rtl/pic_pkg.sv | 41 ++++
 rtl/control_word_sequencer_write_strobe_detect.sv | 48 ++++
 rtl/control_word_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared 8259A command-path definitions: sequencer states and control-word bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } seq_state_t;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ADI  = 2;
  localparam int ICW1_LTIM = 3;

  // With A0=0, D4 marks ICW1 and D3 separates OCW3 from OCW2.
  localparam int SEL_D4 = 4;
  localparam int SEL_D3 = 3;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW2_R   = 7;
  localparam int OCW2_SL  = 6;
  localparam int OCW2_EOI = 5;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  function automatic logic is_icw1(input logic a0, input logic [7:0] dat);
    return ~a0 & dat[SEL_D4];
  endfunction

endpackage

// File: rtl/control_word_sequencer_write_strobe_detect.sv
// Captures A0/data while a CPU write is active and flags the first idle cycle after it.
// commit_o is combinational in that cycle; captured values are stable through it.
module write_strobe_detect (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       write_bar_i,
  input  logic       chip_select_bar_i,
  input  logic       a0_i,
  input  logic [7:0] data_i,
  output logic       commit_o,
  output logic       a0_o,
  output logic [7:0] data_o
);

  logic       wr_active;
  logic       wr_active_q;
  logic       a0_q, a0_d;
  logic [7:0] data_q, data_d;

  assign wr_active = ~write_bar_i & ~chip_select_bar_i;

  always_comb begin
    a0_d   = a0_q;
    data_d = data_q;
    if (wr_active) begin
      a0_d   = a0_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_active_q <= 1'b0;
      a0_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      wr_active_q <= wr_active;
      a0_q        <= a0_d;
      data_q      <= data_d;
    end
  end

  // Clearing wr_active_q on reset drops any write in flight without a commit.
  assign commit_o = wr_active_q & ~wr_active;
  assign a0_o     = a0_q;
  assign data_o   = data_q;

endmodule

// File: rtl/control_word_sequencer.sv
// 8259A ICW/OCW sequencer: steps ICW1->ICW2->[ICW3]->[ICW4] and commits OCW writes in READY.
// Registers update on the edge ending the commit cycle; no backpressure, pulses last one cycle.
module control_word_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] internal_bus,
  input  logic       write_bar,
  input  logic       chip_select_bar,
  input  logic       A0,
  output logic       init_done,
  output logic       init_start,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       single_mode,
  output logic       adi,
  output logic [7:0] cascade_config,
  output logic       upm,
  output logic       auto_eoi,
  output logic       buffer_master,
  output logic       buffered_mode,
  output logic       special_fully_nested,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic       ocw2_rotate,
  output logic       ocw2_specific,
  output logic       ocw2_eoi,
  output logic [2:0] ocw2_level,
  output logic       read_isr_select,
  output logic       special_mask_mode,
  output logic       poll_pulse
);

  logic       commit;
  logic       cmd_a0;
  logic [7:0] cmd_dat;

  write_strobe_detect u_strobe (
    .clk_i            (clk),
    .rst_i            (reset),
    .write_bar_i      (write_bar),
    .chip_select_bar_i(chip_select_bar),
    .a0_i             (A0),
    .data_i           (internal_bus),
    .commit_o         (commit),
    .a0_o             (cmd_a0),
    .data_o           (cmd_dat)
  );

  seq_state_t state_q, state_d;
  logic       ic4_q, ic4_d;
  logic       done_q, done_d, start_q, start_d;
  logic [4:0] vb_q, vb_d;
  logic       ltim_q, ltim_d, sngl_q, sngl_d, adi_q, adi_d;
  logic [7:0] cas_q, cas_d, imr_q, imr_d;
  logic       upm_q, upm_d, aeoi_q, aeoi_d, ms_q, ms_d, buf_q, buf_d, sfnm_q, sfnm_d;
  logic       o2v_q, o2v_d, rot_q, rot_d, sl_q, sl_d, eoi_q, eoi_d;
  logic [2:0] lvl_q, lvl_d;
  logic       ris_q, ris_d, smm_q, smm_d, poll_q, poll_d;

  always_comb begin
    state_d = state_q;
    ic4_d   = ic4_q;
    done_d  = done_q;
    start_d = 1'b0;
    vb_d    = vb_q;
    ltim_d  = ltim_q;
    sngl_d  = sngl_q;
    adi_d   = adi_q;
    cas_d   = cas_q;
    imr_d   = imr_q;
    upm_d   = upm_q;
    aeoi_d  = aeoi_q;
    ms_d    = ms_q;
    buf_d   = buf_q;
    sfnm_d  = sfnm_q;
    o2v_d   = 1'b0;
    rot_d   = rot_q;
    sl_d    = sl_q;
    eoi_d   = eoi_q;
    lvl_d   = lvl_q;
    ris_d   = ris_q;
    smm_d   = smm_q;
    poll_d  = 1'b0;

    if (commit) begin
      if (is_icw1(cmd_a0, cmd_dat)) begin
        ltim_d  = cmd_dat[ICW1_LTIM];
        adi_d   = cmd_dat[ICW1_ADI];
        sngl_d  = cmd_dat[ICW1_SNGL];
        ic4_d   = cmd_dat[ICW1_IC4];
        imr_d   = 8'h00;
        upm_d   = 1'b0;
        aeoi_d  = 1'b0;
        ms_d    = 1'b0;
        buf_d   = 1'b0;
        sfnm_d  = 1'b0;
        smm_d   = 1'b0;
        ris_d   = 1'b0;
        done_d  = 1'b0;
        start_d = 1'b1;
        state_d = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (cmd_a0) begin
            vb_d = cmd_dat[7:3];
            if (!sngl_q)    state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
          WAIT_ICW3: if (cmd_a0) begin
            cas_d   = cmd_dat;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (cmd_a0) begin
            upm_d   = cmd_dat[ICW4_UPM];
            aeoi_d  = cmd_dat[ICW4_AEOI];
            ms_d    = cmd_dat[ICW4_MS];
            buf_d   = cmd_dat[ICW4_BUF];
            sfnm_d  = cmd_dat[ICW4_SFNM];
            state_d = READY;
          end
          READY: begin
            if (cmd_a0) begin
              imr_d = cmd_dat;
            end else if (!cmd_dat[SEL_D3]) begin
              o2v_d = 1'b1;
              rot_d = cmd_dat[OCW2_R];
              sl_d  = cmd_dat[OCW2_SL];
              eoi_d = cmd_dat[OCW2_EOI];
              lvl_d = cmd_dat[2:0];
            end else begin
              if (cmd_dat[OCW3_RR])   ris_d  = cmd_dat[OCW3_RIS];
              if (cmd_dat[OCW3_ESMM]) smm_d  = cmd_dat[OCW3_SMM];
              if (cmd_dat[OCW3_P])    poll_d = 1'b1;
            end
          end
          default: ;
        endcase
        if (state_d == READY) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_ICW1;
      ic4_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      vb_q    <= 5'h00;
      ltim_q  <= 1'b0;
      sngl_q  <= 1'b0;
      adi_q   <= 1'b0;
      cas_q   <= 8'h00;
      imr_q   <= 8'h00;
      upm_q   <= 1'b0;
      aeoi_q  <= 1'b0;
      ms_q    <= 1'b0;
      buf_q   <= 1'b0;
      sfnm_q  <= 1'b0;
      o2v_q   <= 1'b0;
      rot_q   <= 1'b0;
      sl_q    <= 1'b0;
      eoi_q   <= 1'b0;
      lvl_q   <= 3'h0;
      ris_q   <= 1'b0;
      smm_q   <= 1'b0;
      poll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ic4_q   <= ic4_d;
      done_q  <= done_d;
      start_q <= start_d;
      vb_q    <= vb_d;
      ltim_q  <= ltim_d;
      sngl_q  <= sngl_d;
      adi_q   <= adi_d;
      cas_q   <= cas_d;
      imr_q   <= imr_d;
      upm_q   <= upm_d;
      aeoi_q  <= aeoi_d;
      ms_q    <= ms_d;
      buf_q   <= buf_d;
      sfnm_q  <= sfnm_d;
      o2v_q   <= o2v_d;
      rot_q   <= rot_d;
      sl_q    <= sl_d;
      eoi_q   <= eoi_d;
      lvl_q   <= lvl_d;
      ris_q   <= ris_d;
      smm_q   <= smm_d;
      poll_q  <= poll_d;
    end
  end

  assign init_done            = done_q;
  assign init_start           = start_q;
  assign vector_base          = vb_q;
  assign ltim                 = ltim_q;
  assign single_mode          = sngl_q;
  assign adi                  = adi_q;
  assign cascade_config       = cas_q;
  assign upm                  = upm_q;
  assign auto_eoi             = aeoi_q;
  assign buffer_master        = ms_q;
  assign buffered_mode        = buf_q;
  assign special_fully_nested = sfnm_q;
  assign imr                  = imr_q;
  assign ocw2_valid           = o2v_q;
  assign ocw2_rotate          = rot_q;
  assign ocw2_specific        = sl_q;
  assign ocw2_eoi             = eoi_q;
  assign ocw2_level           = lvl_q;
  assign read_isr_select      = ris_q;
  assign special_mask_mode    = smm_q;
  assign poll_pulse           = poll_q;

endmodule
